// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared types and constants for the PWM sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_seq_pkg;

   // Field widths of a stored table entry; the sequencer's W / RPT_W must match these.
   localparam int SEQ_W     = 16;
   localparam int SEQ_RPT_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INIT_TOP = 3'd1,
      INIT_CMP = 3'd2,
      INIT_CNT = 3'd3,
      RUN      = 3'd4,
      UPD_TOP  = 3'd5
   } state_e;

   // Load-bus select codes understood by the PWM counter.
   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_CMP  = 2'b01;
   localparam logic [1:0] SEL_TOP  = 2'b10;
   localparam logic [1:0] SEL_CNT  = 2'b11;

   typedef struct packed {
      logic [SEQ_W-1:0]     top;
      logic [SEQ_W-1:0]     cmp;
      logic [SEQ_RPT_W-1:0] rpt;
   } seq_entry_t;

   // A stored repeat count of zero still plays the entry for one period.
   function automatic logic [SEQ_RPT_W-1:0] rpt_fix(input logic [SEQ_RPT_W-1:0] r);
      return (r == '0) ? SEQ_RPT_W'(1) : r;
   endfunction

endpackage

// File: rtl/pwm_seq_table.sv
// pwm_seq_table: DEPTH-entry register file holding the sequencer's (top, cmp, rpt) table.
// Latency: writes land at the clock edge; reads are combinational (same-cycle read sees old data).
// Backpressure: none; a write is accepted every cycle.
module pwm_seq_table
   import pwm_seq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  seq_entry_t                 wdat,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output seq_entry_t                 rdat
);

   seq_entry_t mem [DEPTH];

   // Storage: cleared on reset so an unprogrammed entry reads as all zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdat;
      end
   end

   assign rdat = mem[raddr];

endmodule

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: walks a (top, cmp, repeat) table and reprograms the PWM counter only at period wraps.
// Latency: 3 cycles from start to the first PWM period; entry changes issue on the wrap cycle.
// Backpressure: none; stop is deferred to the next wrap and start is ignored while busy.
// Optional build macro: PWM_SEQ_PERIOD_CNT_EN adds the period_cnt output.
module pwm_seq_ctrl
   import pwm_seq_pkg::*;
#(
   parameter int W     = SEQ_W,
   parameter int DEPTH = 8,
   parameter int RPT_W = SEQ_RPT_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic [W-1:0]               cfg_top,
   input  logic [W-1:0]               cfg_cmp,
   input  logic [RPT_W-1:0]           cfg_rpt,
   input  logic [$clog2(DEPTH):0]     seq_len,
   input  logic                       loop,
   input  logic                       start,
   input  logic                       stop,
   input  logic [W-1:0]               pwm_cnt,
   output logic [W-1:0]               pwm_d,
   output logic [1:0]                 pwm_sel,
   output logic                       busy,
   output logic [$clog2(DEPTH)-1:0]   idx,
   output logic                       done
`ifdef PWM_SEQ_PERIOD_CNT_EN
   ,
   output logic [31:0]                period_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);

   state_e           state;
   logic [W-1:0]     cur_top;
   logic [W-1:0]     cur_cmp;
   logic [RPT_W-1:0] rpt_left;
   logic [AW:0]      len_q;
   logic             loop_q;
   logic             stop_pend;

   seq_entry_t       wr_ent;
   seq_entry_t       rd_ent;
   logic [AW-1:0]    rd_addr;
   logic [AW-1:0]    nxt_idx;
   logic [AW:0]      idx_inc;
   logic [AW:0]      len_clamped;
   logic             start_ok;
   logic             wrap;
   logic             last_ent;
   logic             last_rpt;
   logic             park;

   assign wr_ent = '{top: cfg_top, cmp: cfg_cmp, rpt: cfg_rpt};

   pwm_seq_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (cfg_we),
      .waddr (cfg_addr),
      .wdat  (wr_ent),
      .raddr (rd_addr),
      .rdat  (rd_ent)
   );

   // Index arithmetic is one bit wider than idx so idx+1 can be compared against len directly.
   assign idx_inc     = {1'b0, idx} + (AW+1)'(1);
   assign last_ent    = (idx_inc == len_q);
   assign nxt_idx     = last_ent ? '0 : idx_inc[AW-1:0];
   // IDLE prefetches entry 0 for the start; otherwise the port looks one entry ahead.
   assign rd_addr     = (state == IDLE) ? '0 : nxt_idx;
   assign len_clamped = (seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : seq_len;

   assign start_ok = (state == IDLE) && start && (seq_len != '0);
   // Equality only: if a new top lands below cnt the counter self-clears, and the next wrap is seen normally.
   assign wrap     = (pwm_cnt == cur_top);
   assign last_rpt = (rpt_left == RPT_W'(1));
   assign park     = stop_pend || (last_rpt && last_ent && !loop_q);
   assign busy     = (state != IDLE);

   // Load-bus drive: a function of state, the current entry and the fed-back counter value.
   always_comb begin
      pwm_sel = SEL_NONE;
      pwm_d   = '0;
      case (state)
         INIT_TOP: begin
            pwm_sel = SEL_TOP;
            pwm_d   = cur_top;
         end
         INIT_CMP: begin
            pwm_sel = SEL_CMP;
            pwm_d   = cur_cmp;
         end
         INIT_CNT: begin
            pwm_sel = SEL_CNT;
            pwm_d   = '0;
         end
         RUN: begin
            if (wrap) begin
               if (park) begin
                  // Compare of zero holds the PWM output low once the sequence is over.
                  pwm_sel = SEL_CMP;
                  pwm_d   = '0;
               end else if (rpt_left > RPT_W'(1)) begin
                  pwm_sel = SEL_NONE;
               end else begin
                  // New cmp goes in on the wrap so it governs cnt=0 of the next period.
                  pwm_sel = SEL_CMP;
                  pwm_d   = rd_ent.cmp;
               end
            end
         end
         UPD_TOP: begin
            pwm_sel = SEL_TOP;
            pwm_d   = cur_top;
         end
         default: begin
            pwm_sel = SEL_NONE;
            pwm_d   = '0;
         end
      endcase
   end

   // Sequencer FSM: start/init loads, repeat counting, entry advance and graceful park.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_top   <= '0;
         cur_cmp   <= '0;
         rpt_left  <= '0;
         len_q     <= '0;
         loop_q    <= 1'b0;
         idx       <= '0;
         done      <= 1'b0;
         stop_pend <= 1'b0;
      end else begin
         done <= 1'b0;
         // A stop anywhere outside IDLE is remembered until the next wrap.
         if (stop && (state != IDLE)) begin
            stop_pend <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start_ok) begin
                  cur_top   <= rd_ent.top;
                  cur_cmp   <= rd_ent.cmp;
                  rpt_left  <= rpt_fix(rd_ent.rpt);
                  len_q     <= len_clamped;
                  loop_q    <= loop;
                  idx       <= '0;
                  stop_pend <= 1'b0;
                  state     <= INIT_TOP;
               end
            end
            INIT_TOP: state <= INIT_CMP;
            INIT_CMP: state <= INIT_CNT;
            INIT_CNT: state <= RUN;
            RUN: begin
               if (wrap) begin
                  if (park) begin
                     stop_pend <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end else if (rpt_left > RPT_W'(1)) begin
                     rpt_left <= rpt_left - RPT_W'(1);
                  end else begin
                     cur_top  <= rd_ent.top;
                     cur_cmp  <= rd_ent.cmp;
                     rpt_left <= rpt_fix(rd_ent.rpt);
                     idx      <= nxt_idx;
                     state    <= UPD_TOP;
                  end
               end
            end
            UPD_TOP: state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PWM_SEQ_PERIOD_CNT_EN
   // Period counter: counts every RUN wrap (the parking one too), saturating, restarted by each start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_cnt <= '0;
      end else if (start_ok) begin
         period_cnt <= '0;
      end else if ((state == RUN) && wrap && (period_cnt != '1)) begin
         period_cnt <= period_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl: drives table-described scenarios against pwm_seq_ctrl with a behavioural PWM counter.
// Latency: expectations are per cycle, sampled on the falling edge.
// Backpressure: n/a.
module tb_pwm_seq_ctrl;
   import pwm_seq_pkg::*;

   localparam int W     = 16;
   localparam int DEPTH = 8;
   localparam int RPT_W = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_we;
   logic [AW-1:0]    cfg_addr;
   logic [W-1:0]     cfg_top;
   logic [W-1:0]     cfg_cmp;
   logic [RPT_W-1:0] cfg_rpt;
   logic [AW:0]      seq_len;
   logic             loop;
   logic             start;
   logic             stop;
   logic [W-1:0]     pwm_cnt;
   logic [W-1:0]     pwm_d;
   logic [1:0]       pwm_sel;
   logic             busy;
   logic [AW-1:0]    idx;
   logic             done;
`ifdef PWM_SEQ_PERIOD_CNT_EN
   logic [31:0]      period_cnt;
`endif

   always #5 clk = ~clk;

   pwm_seq_ctrl #(
      .W     (W),
      .DEPTH (DEPTH),
      .RPT_W (RPT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_top  (cfg_top),
      .cfg_cmp  (cfg_cmp),
      .cfg_rpt  (cfg_rpt),
      .seq_len  (seq_len),
      .loop     (loop),
      .start    (start),
      .stop     (stop),
      .pwm_cnt  (pwm_cnt),
      .pwm_d    (pwm_d),
      .pwm_sel  (pwm_sel),
      .busy     (busy),
      .idx      (idx),
      .done     (done)
`ifdef PWM_SEQ_PERIOD_CNT_EN
      ,
      .period_cnt (period_cnt)
`endif
   );

   // Behavioural PWM counter: load bus first, otherwise count and clear on cnt >= top.
   logic [W-1:0] m_top;
   always @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         m_top   <= '0;
      end else begin
         if (pwm_sel == SEL_CNT)   pwm_cnt <= pwm_d;
         else if (pwm_cnt >= m_top) pwm_cnt <= '0;
         else                      pwm_cnt <= pwm_cnt + 16'd1;
         if (pwm_sel == SEL_TOP)   m_top <= pwm_d;
      end
   end

   // One table row: scenario id, repeat count, inputs held for those cycles, expected outputs.
   typedef struct {
      int         sc;
      int         n;
      bit         st;
      bit         sp;
      bit         rs;
      logic [1:0] sel;
      logic [W-1:0] d;
      bit         busy;
      bit         done;
      int         idx;   // -1: not checked
   } seg_t;

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] d;
      bit           busy;
      bit           done;
      int           idx;
   } exp_t;

   seg_t tbl[$];
   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic add_seg(input int sc, input int n, input bit st, input bit sp, input bit rs,
                          input logic [1:0] sel, input int d, input bit bz, input bit dn, input int ix);
      seg_t s;
      s.sc = sc; s.n = n; s.st = st; s.sp = sp; s.rs = rs;
      s.sel = sel; s.d = W'(d); s.busy = bz; s.done = dn; s.idx = ix;
      tbl.push_back(s);
   endtask

   task automatic chk(input string name, input longint act, input longint req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic wr(input int a, input int t, input int c, input int r);
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_top  = W'(t);
      cfg_cmp  = W'(c);
      cfg_rpt  = RPT_W'(r);
      @(posedge clk); #1;
      cfg_we   = 1'b0;
   endtask

   // Apply every row of one scenario; expectations are queued as stimulus goes out and popped at sampling.
   task automatic run_sc(input int sc);
      int   cyc = 0;
      exp_t e;
      foreach (tbl[i]) begin
         if (tbl[i].sc == sc) begin
            for (int c = 0; c < tbl[i].n; c++) begin
               start = tbl[i].st;
               stop  = tbl[i].sp;
               rst_n = !tbl[i].rs;
               e.sel = tbl[i].sel; e.d = tbl[i].d; e.busy = tbl[i].busy;
               e.done = tbl[i].done; e.idx = tbl[i].idx;
               exp_q.push_back(e);
               @(negedge clk);
               e = exp_q.pop_front();
               chk($sformatf("sc%0d.c%0d.sel", sc, cyc), pwm_sel, e.sel);
               if (e.sel != SEL_NONE) chk($sformatf("sc%0d.c%0d.d", sc, cyc), pwm_d, e.d);
               chk($sformatf("sc%0d.c%0d.busy", sc, cyc), busy, e.busy);
               chk($sformatf("sc%0d.c%0d.done", sc, cyc), done, e.done);
               if (e.idx >= 0) chk($sformatf("sc%0d.c%0d.idx", sc, cyc), idx, e.idx);
               @(posedge clk); #1;
               cyc++;
            end
         end
      end
      start = 1'b0;
      stop  = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_top = '0; cfg_cmp = '0; cfg_rpt = '0;
      seq_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;

      // sc1: single entry {9,3,2}, no loop: init loads, two periods, park at second cnt==9.
      add_seg(1, 1, 1,0,0, 2'b00, 0, 0,0, 0);
      add_seg(1, 1, 0,0,0, 2'b10, 9, 1,0, 0);
      add_seg(1, 1, 0,0,0, 2'b01, 3, 1,0, 0);
      add_seg(1, 1, 0,0,0, 2'b11, 0, 1,0, 0);
      add_seg(1,19, 0,0,0, 2'b00, 0, 1,0, 0);
      add_seg(1, 1, 0,0,0, 2'b01, 0, 1,0, 0);
      add_seg(1, 1, 0,0,0, 2'b00, 0, 0,1, 0);
      add_seg(1, 2, 0,0,0, 2'b00, 0, 0,0, 0);
      // sc2: {9,3,1},{4,2,1} looping; start while busy ignored; stop mid-period parks at next cnt==4.
      add_seg(2, 1, 1,0,0, 2'b00, 0, 0,0, 0);
      add_seg(2, 1, 0,0,0, 2'b10, 9, 1,0, 0);
      add_seg(2, 1, 0,0,0, 2'b01, 3, 1,0, 0);
      add_seg(2, 1, 0,0,0, 2'b11, 0, 1,0, 0);
      add_seg(2, 9, 0,0,0, 2'b00, 0, 1,0, 0);
      add_seg(2, 1, 0,0,0, 2'b01, 2, 1,0, 0);
      add_seg(2, 1, 0,0,0, 2'b10, 4, 1,0, 1);
      add_seg(2, 1, 1,0,0, 2'b00, 0, 1,0, 1);
      add_seg(2, 2, 0,0,0, 2'b00, 0, 1,0, 1);
      add_seg(2, 1, 0,0,0, 2'b01, 3, 1,0, 1);
      add_seg(2, 1, 0,0,0, 2'b10, 9, 1,0, 0);
      add_seg(2, 8, 0,0,0, 2'b00, 0, 1,0, 0);
      add_seg(2, 1, 0,0,0, 2'b01, 2, 1,0, 0);
      add_seg(2, 1, 0,0,0, 2'b10, 4, 1,0, 1);
      add_seg(2, 1, 0,0,0, 2'b00, 0, 1,0, 1);
      add_seg(2, 1, 0,1,0, 2'b00, 0, 1,0, 1);
      add_seg(2, 1, 0,0,0, 2'b00, 0, 1,0, 1);
      add_seg(2, 1, 0,0,0, 2'b01, 0, 1,0, 1);
      add_seg(2, 1, 0,0,0, 2'b00, 0, 0,1, -1);
      add_seg(2, 1, 0,0,0, 2'b00, 0, 0,0, -1);
      // sc3: rpt=0 behaves as one period.
      add_seg(3, 1, 1,0,0, 2'b00, 0, 0,0, -1);
      add_seg(3, 1, 0,0,0, 2'b10, 5, 1,0, 0);
      add_seg(3, 1, 0,0,0, 2'b01, 1, 1,0, 0);
      add_seg(3, 1, 0,0,0, 2'b11, 0, 1,0, 0);
      add_seg(3, 5, 0,0,0, 2'b00, 0, 1,0, 0);
      add_seg(3, 1, 0,0,0, 2'b01, 0, 1,0, 0);
      add_seg(3, 1, 0,0,0, 2'b00, 0, 0,1, 0);
      add_seg(3, 1, 0,0,0, 2'b00, 0, 0,0, 0);
      // sc6: start with seq_len=0 and stop in IDLE are both ignored.
      add_seg(6, 1, 1,0,0, 2'b00, 0, 0,0, 0);
      add_seg(6, 1, 0,1,0, 2'b00, 0, 0,0, 0);
      add_seg(6, 2, 0,0,0, 2'b00, 0, 0,0, 0);
      // sc4: start+stop in the same IDLE cycle: start wins, both repeats of {5,1,2} play.
      add_seg(4, 1, 1,1,0, 2'b00, 0, 0,0, 0);
      add_seg(4, 1, 0,0,0, 2'b10, 5, 1,0, 0);
      add_seg(4, 1, 0,0,0, 2'b01, 1, 1,0, 0);
      add_seg(4, 1, 0,0,0, 2'b11, 0, 1,0, 0);
      add_seg(4,11, 0,0,0, 2'b00, 0, 1,0, 0);
      add_seg(4, 1, 0,0,0, 2'b01, 0, 1,0, 0);
      add_seg(4, 1, 0,0,0, 2'b00, 0, 0,1, 0);
      add_seg(4, 1, 0,0,0, 2'b00, 0, 0,0, 0);
      // sc5: stop during INIT_CMP is deferred to the first wrap.
      add_seg(5, 1, 1,0,0, 2'b00, 0, 0,0, 0);
      add_seg(5, 1, 0,0,0, 2'b10, 5, 1,0, 0);
      add_seg(5, 1, 0,1,0, 2'b01, 1, 1,0, 0);
      add_seg(5, 1, 0,0,0, 2'b11, 0, 1,0, 0);
      add_seg(5, 5, 0,0,0, 2'b00, 0, 1,0, 0);
      add_seg(5, 1, 0,0,0, 2'b01, 0, 1,0, 0);
      add_seg(5, 1, 0,0,0, 2'b00, 0, 0,1, 0);
      add_seg(5, 1, 0,0,0, 2'b00, 0, 0,0, 0);
      // sc7: reset in RUN aborts without a park load; table then reads back zero.
      add_seg(7, 1, 1,0,0, 2'b00, 0, 0,0, 0);
      add_seg(7, 1, 0,0,0, 2'b10, 5, 1,0, 0);
      add_seg(7, 1, 0,0,0, 2'b01, 1, 1,0, 0);
      add_seg(7, 1, 0,0,0, 2'b11, 0, 1,0, 0);
      add_seg(7, 3, 0,0,0, 2'b00, 0, 1,0, 0);
      add_seg(7, 1, 0,0,1, 2'b00, 0, 1,0, 0);
      add_seg(7, 1, 0,0,0, 2'b00, 0, 0,0, 0);
      add_seg(7, 1, 1,0,0, 2'b00, 0, 0,0, 0);
      add_seg(7, 1, 0,0,0, 2'b10, 0, 1,0, 0);
      add_seg(7, 1, 0,0,0, 2'b01, 0, 1,0, 0);
      add_seg(7, 1, 0,0,0, 2'b11, 0, 1,0, 0);
      add_seg(7, 1, 0,0,0, 2'b01, 0, 1,0, 0);
      add_seg(7, 1, 0,0,0, 2'b00, 0, 0,1, 0);
      add_seg(7, 1, 0,0,0, 2'b00, 0, 0,0, 0);
      // sc8: seq_len=15 clamps to 8; entries {1,k+1,1} walk idx 0..7 then park.
      add_seg(8, 1, 1,0,0, 2'b00, 0, 0,0, 0);
      add_seg(8, 1, 0,0,0, 2'b10, 1, 1,0, 0);
      add_seg(8, 1, 0,0,0, 2'b01, 1, 1,0, 0);
      add_seg(8, 1, 0,0,0, 2'b11, 0, 1,0, 0);
      add_seg(8, 1, 0,0,0, 2'b00, 0, 1,0, 0);
      add_seg(8, 1, 0,0,0, 2'b01, 2, 1,0, 0);
      for (int k = 1; k < 7; k++) begin
         add_seg(8, 1, 0,0,0, 2'b10, 1,   1,0, k);
         add_seg(8, 1, 0,0,0, 2'b01, k+2, 1,0, k);
      end
      add_seg(8, 1, 0,0,0, 2'b10, 1, 1,0, 7);
      add_seg(8, 1, 0,0,0, 2'b01, 0, 1,0, 7);
      add_seg(8, 1, 0,0,0, 2'b00, 0, 0,1, 7);
      add_seg(8, 1, 0,0,0, 2'b00, 0, 0,0, 7);

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.sel", pwm_sel, 0);
      chk("rst.d", pwm_d, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.idx", idx, 0);
`ifdef PWM_SEQ_PERIOD_CNT_EN
      chk("rst.period_cnt", period_cnt, 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      wr(0, 9, 3, 2); seq_len = 1; loop = 1'b0;
      run_sc(1);
`ifdef PWM_SEQ_PERIOD_CNT_EN
      chk("sc1.period_cnt", period_cnt, 2);
`endif
      wr(0, 9, 3, 1); wr(1, 4, 2, 1); seq_len = 2; loop = 1'b1;
      run_sc(2);
`ifdef PWM_SEQ_PERIOD_CNT_EN
      chk("sc2.period_cnt", period_cnt, 4);
`endif
      wr(0, 5, 1, 0); seq_len = 1; loop = 1'b0;
      run_sc(3);
      seq_len = 0;
      run_sc(6);
      wr(0, 5, 1, 2); seq_len = 1;
      run_sc(4);
      run_sc(5);
      run_sc(7);
`ifdef PWM_SEQ_PERIOD_CNT_EN
      chk("sc7.period_cnt", period_cnt, 1);
`endif
      for (int k = 0; k < 8; k++) wr(k, 1, k + 1, 1);
      seq_len = 15; loop = 1'b0;
      run_sc(8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
